// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback / register-file block.
package wb_regfile_pkg;

   // Architectural register count; the top index is the PC and has no storage.
   localparam int REG_COUNT   = 16;
   localparam int STORED_REGS = REG_COUNT - 1;

   // Register index that aliases the program counter (reads return PC+8).
   localparam logic [3:0] PC_IDX = 4'hF;

   // Writeback source select encodings.
   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_sel_e;

   // True when an index refers to the PC alias rather than a stored register.
   function automatic logic is_pc(input logic [3:0] idx);
      return (idx == PC_IDX);
   endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipe, decode stage and the register file.
// Signal suffixes are from the register file's point of view.
interface wb_regfile_if #(parameter int N = 32);

   logic [N-1:0] ReadData_i;
   logic [N-1:0] AluResult_i;
   logic         WBSelect_i;
   logic         RF_WE_i;
   logic [3:0]   A3_i;
   logic [3:0]   A1_i;
   logic [3:0]   A2_i;
   logic [N-1:0] PC8_i;
   logic [N-1:0] RD1_o;
   logic [N-1:0] RD2_o;
   logic [N-1:0] WD3_o;
   logic [N-1:0] WBCount_o;

   // Pipeline / decode side: drives requests, observes results.
   modport master (
      output ReadData_i, AluResult_i, WBSelect_i, RF_WE_i,
      output A3_i, A1_i, A2_i, PC8_i,
      input  RD1_o, RD2_o, WD3_o, WBCount_o
   );

   // Register-file side.
   modport slave (
      input  ReadData_i, AluResult_i, WBSelect_i, RF_WE_i,
      input  A3_i, A1_i, A2_i, PC8_i,
      output RD1_o, RD2_o, WD3_o, WBCount_o
   );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Writeback source selector: memory load data or ALU result.
module wb_mux
   import wb_regfile_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] ReadData_i,
   input  logic [N-1:0] AluResult_i,
   input  logic         WBSelect_i,
   output logic [N-1:0] WD3_o
);

   // Pure combinational select, deliberately independent of the write enable.
   always_comb begin
      WD3_o = AluResult_i;
      if (WBSelect_i == WB_MEM) begin
         WD3_o = ReadData_i;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// 15-entry register file with PC alias at index 15, write-to-read bypass
// on both read ports and a saturating count of committed writes.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         CLK,
   input  logic         RST,
   wb_regfile_if.slave  bus
);

   logic [N-1:0] wd3;
   logic         we_commit;
   logic [N-1:0] rf_rd [REG_COUNT];
   logic [3:0]   rd_addr [2];
   logic [N-1:0] rd_data [2];
   logic [N-1:0] cnt_q;
   logic [N-1:0] cnt_d;

   wb_mux #(.N(N)) u_wb_mux (
      .ReadData_i  (bus.ReadData_i),
      .AluResult_i (bus.AluResult_i),
      .WBSelect_i  (bus.WBSelect_i),
      .WD3_o       (wd3)
   );

   assign bus.WD3_o = wd3;

   // A write only commits for a stored register; index 15 is silently dropped.
   assign we_commit = bus.RF_WE_i && !is_pc(bus.A3_i);

   genvar gi;
   generate
      for (gi = 0; gi < STORED_REGS; gi++) begin : g_reg
         logic [N-1:0] reg_q;
         logic [N-1:0] reg_d;

         assign reg_d = (we_commit && (bus.A3_i == 4'(gi))) ? wd3 : reg_q;

         // Register storage, cleared immediately by reset.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               reg_q <= '0;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign rf_rd[gi] = reg_q;
      end
   endgenerate

   // Index 15 has no storage; the read path substitutes PC+8 before this is used.
   assign rf_rd[REG_COUNT-1] = '0;

   assign rd_addr[0] = bus.A1_i;
   assign rd_addr[1] = bus.A2_i;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [N-1:0] rd_val;

         // Read port: PC alias first, then same-cycle bypass, then storage.
         // Bypass is suppressed during reset so reads show the cleared state.
         always_comb begin
            rd_val = rf_rd[rd_addr[gi]];
            if (is_pc(rd_addr[gi])) begin
               rd_val = bus.PC8_i;
            end else if (!RST && we_commit && (rd_addr[gi] == bus.A3_i)) begin
               rd_val = wd3;
            end
         end

         assign rd_data[gi] = rd_val;
      end
   endgenerate

   assign bus.RD1_o = rd_data[0];
   assign bus.RD2_o = rd_data[1];

   // Committed-write counter, holding at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (we_commit && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.WBCount_o = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a 32-bit instance for function/reset and
// a 4-bit instance for counter saturation. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when outputs are sampled.
module tb_wb_regfile;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   int checks   = 0;
   int failures = 0;

   exp_t        sb[$];
   logic [31:0] model_rf [15];
   logic [31:0] exp_cnt;
   logic [3:0]  exp_cnt4;

   wb_regfile_if #(.N(32)) if32 ();
   wb_regfile_if #(.N(4))  if4 ();

   wb_regfile #(.N(32)) u32 (
      .CLK (CLK),
      .RST (RST),
      .bus (if32.slave)
   );

   wb_regfile #(.N(4)) u4 (
      .CLK (CLK),
      .RST (RST),
      .bus (if4.slave)
   );

   always #5 CLK = ~CLK;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   // One rising edge; the bench's own model commits writes alongside it.
   task automatic clk_edge();
      logic [31:0] wd;
      wd = (if32.WBSelect_i) ? if32.ReadData_i : if32.AluResult_i;
      if (!RST && if32.RF_WE_i && (if32.A3_i != 4'hF)) begin
         model_rf[if32.A3_i] = wd;
         if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
      end
      if (!RST && if4.RF_WE_i && (if4.A3_i != 4'hF)) begin
         if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 1;
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      for (int i = 0; i < 15; i++) model_rf[i] = '0;
      exp_cnt  = '0;
      exp_cnt4 = '0;

      if32.ReadData_i  = '0;
      if32.AluResult_i = '0;
      if32.WBSelect_i  = 1'b0;
      if32.RF_WE_i     = 1'b0;
      if32.A3_i        = 4'd0;
      if32.A1_i        = 4'd0;
      if32.A2_i        = 4'd0;
      if32.PC8_i       = 32'h0000_0100;
      if4.ReadData_i   = '0;
      if4.AluResult_i  = '0;
      if4.WBSelect_i   = 1'b0;
      if4.RF_WE_i      = 1'b0;
      if4.A3_i         = 4'd0;
      if4.A1_i         = 4'd0;
      if4.A2_i         = 4'd0;
      if4.PC8_i        = 4'h8;

      // Power-up reset, released between edges.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      push("reset_count", 32'd0);
      check(if32.WBCount_o);
      push("reset_rd1_r0", 32'd0);
      check(if32.RD1_o);

      // Seed R1 so the asynchronous reset has something to clear.
      if32.RF_WE_i = 1'b1; if32.A3_i = 4'd1; if32.WBSelect_i = 1'b0;
      if32.AluResult_i = 32'h0000_0011;
      clk_edge();
      if32.RF_WE_i = 1'b0; if32.A1_i = 4'd1;
      #1;
      push("seed_r1", model_rf[1]);
      check(if32.RD1_o);
      push("seed_count", exp_cnt);
      check(if32.WBCount_o);

      // Asynchronous reset pulse between edges, bypass attempt while held.
      #1;
      RST = 1'b1;
      for (int i = 0; i < 15; i++) model_rf[i] = '0;
      exp_cnt = '0;
      #1;
      push("async_count", 32'd0);
      check(if32.WBCount_o);
      for (int a = 0; a < 15; a++) begin
         if32.A1_i = 4'(a);
         if32.A2_i = 4'(14 - a);
         #1;
         push($sformatf("async_rd1_a%0d", a), 32'd0);
         check(if32.RD1_o);
         push($sformatf("async_rd2_a%0d", 14 - a), 32'd0);
         check(if32.RD2_o);
      end
      if32.A1_i = 4'hF;
      #1;
      push("async_rd1_pc", if32.PC8_i);
      check(if32.RD1_o);
      if32.RF_WE_i = 1'b1; if32.A3_i = 4'd2; if32.WBSelect_i = 1'b0;
      if32.AluResult_i = 32'h0000_0022; if32.A1_i = 4'd2;
      #1;
      push("reset_no_bypass", 32'd0);
      check(if32.RD1_o);
      RST = 1'b0;
      #1;
      push("bypass_after_release", 32'h0000_0022);
      check(if32.RD1_o);
      clk_edge();
      if32.RF_WE_i = 1'b0;
      #1;
      push("first_write_after_reset", model_rf[2]);
      check(if32.RD1_o);
      push("count_after_reset", exp_cnt);
      check(if32.WBCount_o);

      // Write/read through the memory source.
      if32.RF_WE_i = 1'b1; if32.A3_i = 4'd3; if32.WBSelect_i = 1'b1;
      if32.ReadData_i = 32'h7894_ACD0;
      clk_edge();
      if32.RF_WE_i = 1'b0; if32.A1_i = 4'd3;
      #1;
      push("wr_rd_r3", 32'h7894_ACD0);
      check(if32.RD1_o);
      push("wr_rd_count", exp_cnt);
      check(if32.WBCount_o);

      // Same-cycle bypass on both ports.
      if32.RF_WE_i = 1'b1; if32.A3_i = 4'd5; if32.WBSelect_i = 1'b0;
      if32.AluResult_i = 32'h0000_0002; if32.A1_i = 4'd5; if32.A2_i = 4'd5;
      #1;
      push("bypass_rd1", 32'h0000_0002);
      check(if32.RD1_o);
      push("bypass_rd2", 32'h0000_0002);
      check(if32.RD2_o);
      push("bypass_wd3", 32'h0000_0002);
      check(if32.WD3_o);
      clk_edge();
      if32.RF_WE_i = 1'b0;
      #1;
      push("r5_stored", model_rf[5]);
      check(if32.RD2_o);

      // Write aimed at R15 is dropped; read of R15 returns PC+8.
      if32.RF_WE_i = 1'b1; if32.A3_i = 4'hF; if32.WBSelect_i = 1'b0;
      if32.AluResult_i = 32'hDEAD_BEEF; if32.PC8_i = 32'h0000_0108;
      if32.A1_i = 4'hF; if32.A2_i = 4'd3;
      #1;
      push("r15_rd1", 32'h0000_0108);
      check(if32.RD1_o);
      push("r15_wd3", 32'hDEAD_BEEF);
      check(if32.WD3_o);
      push("r15_no_bypass_rd2", model_rf[3]);
      check(if32.RD2_o);
      clk_edge();
      #1;
      push("r15_count", exp_cnt);
      check(if32.WBCount_o);

      // Disabled write leaves R3 and the count alone; mux still follows inputs.
      if32.RF_WE_i = 1'b0; if32.A3_i = 4'd3; if32.WBSelect_i = 1'b1;
      if32.ReadData_i = 32'hFFFF_FFFF; if32.A1_i = 4'd3;
      #1;
      push("disabled_wd3", 32'hFFFF_FFFF);
      check(if32.WD3_o);
      push("disabled_no_bypass", 32'h7894_ACD0);
      check(if32.RD1_o);
      clk_edge();
      #1;
      push("disabled_r3", 32'h7894_ACD0);
      check(if32.RD1_o);
      push("disabled_count", exp_cnt);
      check(if32.WBCount_o);

      // Bypass on one port only.
      if32.RF_WE_i = 1'b1; if32.A3_i = 4'd3; if32.WBSelect_i = 1'b0;
      if32.AluResult_i = 32'h1234_5678; if32.A1_i = 4'd3; if32.A2_i = 4'd5;
      #1;
      push("split_rd1", 32'h1234_5678);
      check(if32.RD1_o);
      push("split_rd2", model_rf[5]);
      check(if32.RD2_o);
      clk_edge();
      if32.RF_WE_i = 1'b0;
      #1;
      push("split_r3_stored", model_rf[3]);
      check(if32.RD1_o);
      push("split_count", exp_cnt);
      check(if32.WBCount_o);

      // Saturation on the 4-bit instance.
      if4.RF_WE_i = 1'b1; if4.A3_i = 4'd1; if4.WBSelect_i = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if4.AluResult_i = 4'(i);
         clk_edge();
      end
      #1;
      push("n4_count_14", 32'(exp_cnt4));
      check(32'(if4.WBCount_o));
      if4.AluResult_i = 4'hA;
      clk_edge();
      #1;
      push("n4_count_15", 32'h0000_000F);
      check(32'(if4.WBCount_o));
      repeat (3) clk_edge();
      #1;
      push("n4_count_saturated", 32'h0000_000F);
      check(32'(if4.WBCount_o));
      if4.RF_WE_i = 1'b0; if4.A1_i = 4'd1;
      #1;
      push("n4_r1", 32'h0000_000A);
      check(32'(if4.RD1_o));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
